uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte holding register.
// The line is sampled at mid-bit, timed from the falling edge of the start
// bit. Holds one unread byte; a newer byte is dropped (overrun) if the
// previous one has not been read.
module uart_rx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] dout,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    WAIT_HIGH
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_data;
  logic        r_sync1;
  logic        r_sync2;
  logic [7:0]  r_dout;
  logic        r_valid;
  logic        r_overrun;
  logic        r_frame_err;

  logic        w_rx_s;
  logic        w_deliver;

  assign w_rx_s = r_sync2;

  // Good stop bit sampled this cycle: the assembled byte is ready to hand over.
  assign w_deliver = (r_state == STOP_BIT) && (r_cnt == C_FULL) && w_rx_s;

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM plus the host-facing holding register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_data      <= 8'h00;
      r_dout      <= 8'h00;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      // A read in the same cycle as a delivery frees the slot for the new byte.
      if (w_deliver) begin
        if (!r_valid || re) begin
          r_dout    <= r_data;
          r_valid   <= 1'b1;
          r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (re && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          r_idx <= 3'd0;
          if (!w_rx_s) r_state <= START_BIT;
        end
        START_BIT: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= 16'd0;
            // Line back high at mid-start is a glitch, not a frame.
            r_state <= w_rx_s ? IDLE : DATA_BITS;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA_BITS: begin
          if (r_cnt == C_FULL) begin
            r_cnt         <= 16'd0;
            r_data[r_idx] <= w_rx_s;
            if (r_idx == 3'd7) begin
              r_idx   <= 3'd0;
              r_state <= STOP_BIT;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP_BIT: begin
          if (r_cnt == C_FULL) begin
            r_cnt <= 16'd0;
            // Leaving at mid-stop keeps a back-to-back start edge visible.
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          // A break holds the line low; wait it out so it reports only once.
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx. Every cycle's inputs and outputs
// are recorded; a frame-level model derives the expected outputs from the
// recorded line, and each cycle is compared against it. A few literal
// expectations pin both the DUT and the model.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int NMAX = 4096;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       re    = 1'b0;
  logic [7:0] dout;
  logic       valid, overrun, frame_err, busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int ncyc = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .re(re),
    .dout(dout), .valid(valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle record: inputs as driven, outputs as seen mid-cycle
  logic        rx_h  [NMAX];
  logic        re_h  [NMAX];
  logic        rs_h  [NMAX];
  logic [11:0] obs_h [NMAX];

  always @(negedge clk) begin
    if (cyc < NMAX) begin
      rx_h[cyc]  <= rx;
      re_h[cyc]  <= re;
      rs_h[cyc]  <= rst_n;
      obs_h[cyc] <= {busy, frame_err, overrun, valid, dout};
    end
  end

  // model arrays
  logic       s2  [NMAX];
  logic       s1  [NMAX];
  logic       eb  [NMAX];
  logic       ef  [NMAX];
  logic       dlv [NMAX];
  logic [7:0] dby [NMAX];
  logic [11:0] exp_h [NMAX];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
    end
  endtask

  function automatic bit live(input int c);
    return (c >= 1) && (c < ncyc) && (rs_h[c] === 1'b1);
  endfunction

  // Frame-level receiver model: find start edges on the synchronized line,
  // read the bits at their mid-points, then apply the holding-register rules.
  task automatic run_model();
    int c, t0, k, stp;
    logic [7:0] b;
    logic v, o;
    logic [7:0] d;
    for (int i = 0; i < ncyc; i++) begin
      if (i < 2 || !rs_h[i] || !rs_h[i-1]) begin
        s1[i] = 1'b1; s2[i] = 1'b1;
      end else begin
        s1[i] = rx_h[i-1]; s2[i] = s1[i-1];
      end
      eb[i] = 0; ef[i] = 0; dlv[i] = 0; dby[i] = 8'h00;
    end
    c = 1;
    while (c < ncyc) begin
      if (!live(c) || s2[c]) begin c++; continue; end
      t0  = c;
      stp = t0 + HALF + 9 * CPB;
      k   = t0 + 1;
      while (k <= stp && live(k) && !(k == t0 + HALF + 1 && s2[t0 + HALF])) begin
        eb[k] = 1; k++;
      end
      if (k <= stp) begin c = k; continue; end
      for (int i = 0; i < 8; i++) b[i] = s2[t0 + HALF + (i + 1) * CPB];
      if (s2[stp]) begin
        dlv[stp] = 1; dby[stp] = b; c = stp + 1;
      end else begin
        k = stp + 1;
        if (live(k)) ef[k] = 1;
        while (live(k)) begin
          eb[k] = 1;
          if (s2[k]) break;
          k++;
        end
        c = live(k) ? k + 1 : k;
      end
    end
    v = 0; o = 0; d = 8'h00;
    for (int i = 1; i < ncyc; i++) begin
      if (i < 2 || !rs_h[i] || !rs_h[i-1]) begin
        v = 0; o = 0; d = 8'h00;
      end else if (dlv[i-1]) begin
        if (!v || re_h[i-1]) begin v = 1; d = dby[i-1]; o = 0; end
        else o = 1;
      end else if (re_h[i-1] && v) begin
        v = 0; o = 0;
      end
      exp_h[i] = {eb[i], ef[i], o, v, d};
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, output int s);
    s  = cyc;
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = stop; tick(CPB);
  endtask

  task automatic rd();
    re = 1'b1; tick(1); re = 1'b0; tick(2);
  endtask

  task automatic pulse_after_rise(output int rise);
    int n;
    n    = 0;
    rise = 0;
    while (valid !== 1'b1 && n < 400) begin tick(1); n++; end
    if (valid !== 1'b1) begin
      chk("re_wait_timeout", 32'd0, 32'd1);
    end else begin
      rise = cyc;
      tick(1); re = 1'b1;
      tick(1); re = 1'b0;
    end
  endtask

  initial begin
    int sA, rA, sF, sC, hC, s11, s22, rB, sR, rR, s5A, s01, s80, r1, r2, cnt, ecnt;

    tick(4);
    rst_n = 1'b1;
    tick(10);

    // 0xA5, good stop, then read
    send(8'hA5, 1'b1, sA);
    re = 1'b1; rA = cyc; tick(1); re = 1'b0;
    tick(20);

    // 4-cycle glitch
    sF = cyc; rx = 1'b0; tick(4); rx = 1'b1; tick(30);

    // 0x3C with bad stop, line held low as a break
    send(8'h3C, 1'b0, sC);
    tick(400 - CPB);
    rx = 1'b1; hC = cyc; tick(30);

    // back-to-back without reading -> overrun
    send(8'h11, 1'b1, s11);
    send(8'h22, 1'b1, s22);
    tick(20);
    re = 1'b1; rB = cyc; tick(1); re = 1'b0; tick(5);

    // reset during data bit 4 of 0xFF, then a clean frame
    sR = cyc;
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(4 * CPB + 5);
    rst_n = 1'b0; rR = cyc; tick(3);
    rst_n = 1'b1; tick(20);
    send(8'h5A, 1'b1, s5A);
    tick(20);
    rd();

    // back-to-back with prompt reads
    fork
      begin send(8'h01, 1'b1, s01); send(8'h80, 1'b1, s80); end
      begin pulse_after_rise(r1); pulse_after_rise(r2); end
    join
    tick(20);

    @(negedge clk);
    ncyc = cyc;
    run_model();

    for (int c = 2; c < ncyc; c++)
      chk($sformatf("cycle%0d {busy,ferr,ovr,valid,dout}", c), 32'(obs_h[c]), 32'(exp_h[c]));

    // reset state
    chk("reset_outputs", 32'(obs_h[2]), 32'd0);

    // 0xA5 timing: valid rises exactly at T0+153
    chk("A5_valid_before", 32'(obs_h[sA + 2 + 152][8]), 32'd0);
    chk("A5_valid_rise",   32'(obs_h[sA + 2 + 153][8]), 32'd1);
    chk("A5_dout",         32'(obs_h[sA + 2 + 153][7:0]), 32'hA5);
    chk("A5_flags",        32'(obs_h[sA + 2 + 153][10:9]), 32'd0);
    chk("A5_model_pin",    32'(exp_h[sA + 2 + 153][8:0]), 32'h1A5);
    chk("A5_read_clears",  32'(obs_h[rA + 1][8]), 32'd0);

    // glitch: busy exactly 8 cycles, no valid/frame_err
    cnt = 0; ecnt = 0;
    for (int c = sF; c < sF + 30; c++) begin
      cnt  += int'(obs_h[c][11]);
      ecnt += int'(eb[c]);
    end
    chk("glitch_busy_cycles", 32'(cnt), 32'd8);
    chk("glitch_model_busy",  32'(ecnt), 32'd8);
    chk("glitch_no_flags",    32'(obs_h[sF + 12][10:8]), 32'd0);

    // break: one frame_err pulse at T0+153, valid stays 0
    cnt = 0; ecnt = 0;
    for (int c = sC; c < hC + 30; c++) begin
      cnt  += int'(obs_h[c][10]);
      ecnt += int'(ef[c]);
      if (obs_h[c][8] !== 1'b0) chk("break_valid_low", 32'(obs_h[c][8]), 32'd0);
    end
    chk("break_ferr_count", 32'(cnt), 32'd1);
    chk("break_model_ferr", 32'(ecnt), 32'd1);
    chk("break_ferr_time",  32'(obs_h[sC + 2 + 153][10]), 32'd1);
    chk("break_busy_held",  32'(obs_h[hC + 2][11]), 32'd1);
    chk("break_busy_drop",  32'(obs_h[hC + 3][11]), 32'd0);

    // overrun
    chk("ovr_state",  32'(obs_h[s22 + 2 + 154][9:0]), 32'h311);
    chk("ovr_read",   32'(obs_h[rB + 1][9:8]), 32'd0);

    // reset mid-frame, then 0x5A
    chk("midreset_busy_before", 32'(obs_h[rR - 1][11]), 32'd1);
    chk("midreset_outputs",     32'(obs_h[rR]), 32'd0);
    chk("after_reset_5A",       32'(obs_h[s5A + 2 + 153][8:0]), 32'h15A);

    // prompt reads: both delivered in order, no overrun
    chk("b2b_first",  32'(obs_h[r1][8:0]), 32'h101);
    chk("b2b_second", 32'(obs_h[r2][8:0]), 32'h180);
    chk("b2b_gap",    32'(r2 - r1), 32'(10 * CPB));
    cnt = 0;
    for (int c = s01; c < ncyc; c++) cnt += int'(obs_h[c][9]);
    chk("b2b_no_overrun", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
